// File: rtl/debug_dump_tx.sv
// Register-file dump engine: walks the debug read select over 0..NUM_REGS-1, captures
// each 32-bit word and sends it MSB byte first as 8N1 UART frames on tx.
// Optional feature macro: DEBUG_DUMP_HEADER_EN adds a 0xA5 sync byte at the start of the
// dump and an index byte ahead of each register's four data bytes.
module debug_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Debug_out,
  output logic [4:0]  Debug_Source_select,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

`ifdef DEBUG_DUMP_HEADER_EN
  localparam logic       HeaderEn = 1'b1;
  localparam logic [2:0] LastByte = 3'd4;  // index byte + 4 data bytes
`else
  localparam logic       HeaderEn = 1'b0;
  localparam logic [2:0] LastByte = 3'd3;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StCapture,
    StStartBit,
    StDataBits,
    StStopBit,
    StNext,
    StDone
  } state_e;

  state_e state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [4:0]  index_q, index_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        sync_q, sync_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [1:0]  data_sel;
  logic [7:0]  word_byte;
  logic [7:0]  next_byte;
  logic        bit_end;

  assign bit_end = (baud_q == BaudLast);

  // Byte to be sent in the frame that is currently in its start bit.
  always_comb begin
`ifdef DEBUG_DUMP_HEADER_EN
    data_sel = 2'(byte_cnt_q - 3'd1);
`else
    data_sel = byte_cnt_q[1:0];
`endif
    unique case (data_sel)
      2'd0:    word_byte = word_q[31:24];
      2'd1:    word_byte = word_q[23:16];
      2'd2:    word_byte = word_q[15:8];
      default: word_byte = word_q[7:0];
    endcase
`ifdef DEBUG_DUMP_HEADER_EN
    if (sync_q) begin
      next_byte = 8'hA5;
    end else if (byte_cnt_q == 3'd0) begin
      next_byte = {3'b000, index_q};
    end else begin
      next_byte = word_byte;
    end
`else
    next_byte = word_byte;
`endif
  end

  // Next-state logic; tx/busy/done are computed here and registered so no input reaches them
  // combinationally.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    index_d    = index_q;
    sel_d      = sel_q;
    word_d     = word_q;
    shreg_d    = shreg_q;
    sync_d     = sync_q;
    tx_d       = tx_q;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = StSelect;
          index_d = 5'd0;
          sel_d   = 5'd0;
          sync_d  = HeaderEn;
        end
      end
      // Select is already driven during this cycle, so the register file output is valid now.
      StSelect: begin
        word_d  = Debug_out;
        state_d = StCapture;
      end
      StCapture: begin
        byte_cnt_d = 3'd0;
        baud_d     = '0;
        tx_d       = 1'b0;
        state_d    = StStartBit;
      end
      StStartBit: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          shreg_d = next_byte;
          tx_d    = next_byte[0];
          state_d = StDataBits;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StDataBits: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStopBit;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {shreg_q[0], shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStopBit: begin
        if (bit_end) begin
          baud_d = '0;
          if (sync_q) begin
            // Sync byte does not consume a byte slot of the register.
            sync_d  = 1'b0;
            tx_d    = 1'b0;
            state_d = StStartBit;
          end else if (byte_cnt_q < LastByte) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            tx_d       = 1'b0;
            state_d    = StStartBit;
          end else begin
            state_d = StNext;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StNext: begin
        if (index_q == LastIdx) begin
          state_d = StDone;
        end else begin
          index_d = index_q + 5'd1;
          sel_d   = index_q + 5'd1;
          state_d = StSelect;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_cnt_q <= 3'd0;
      index_q    <= 5'd0;
      sel_q      <= 5'd0;
      word_q     <= 32'd0;
      shreg_q    <= 8'd0;
      sync_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      index_q    <= index_d;
      sel_q      <= sel_d;
      word_q     <= word_d;
      shreg_q    <= shreg_d;
      sync_q     <= sync_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Debug_Source_select = sel_q;
  assign tx                  = tx_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule
